// File: rtl/image_frame_sender.sv
// rtl/image_frame_sender.sv - frame memory plus byte-stream sender: 4-byte LE header (width, height) then raster pixels.
// Writes are accepted only while idle so a frame in flight never changes underneath the stream.
module image_frame_sender #(
  parameter int DATA_BITS  = 8,
  parameter int MAX_PIXELS = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk_a,
  input  logic                 rst,
  input  logic                 load_we,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic [15:0]          width,
  input  logic [15:0]          height,
  input  logic                 start,
  input  logic                 ready_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_PIX,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [15:0]          w_lat;
  logic [15:0]          h_lat;
  logic [ADDR_BITS-1:0] last_idx;
  logic [ADDR_BITS-1:0] pix_idx;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [1:0]           hdr_idx;
  logic [DATA_BITS-1:0] mem [0:MAX_PIXELS-1];
  logic [DATA_BITS-1:0] rd_data;
  logic [31:0]          prod;
  logic                 dims_ok;
  logic                 accept;

  assign prod    = {16'd0, width} * {16'd0, height};
  assign dims_ok = (width != 16'd0) && (height != 16'd0) && (prod <= 32'(MAX_PIXELS));
  assign accept  = (state == S_IDLE) && start && dims_ok;

  always_comb begin
    state_nx  = state;
    valid_out = 1'b0;
    data_out  = '0;
    rd_addr   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_nx = S_HDR;
      end
      S_HDR: begin
        valid_out = 1'b1;
        case (hdr_idx)
          2'd0:    data_out = DATA_BITS'(w_lat[7:0]);
          2'd1:    data_out = DATA_BITS'(w_lat[15:8]);
          2'd2:    data_out = DATA_BITS'(h_lat[7:0]);
          default: data_out = DATA_BITS'(h_lat[15:8]);
        endcase
        if (ready_out && hdr_idx == 2'd3) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = S_PIX;
      S_PIX: begin
        valid_out = 1'b1;
        data_out  = rd_data;
        rd_addr   = pix_idx;
        // Prefetch the next pixel on a beat so back-to-back beats need no bubble.
        if (ready_out) begin
          rd_addr = pix_idx + 1'b1;
          if (pix_idx == last_idx) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (rst) begin
      state    <= S_IDLE;
      w_lat    <= '0;
      h_lat    <= '0;
      last_idx <= '0;
      pix_idx  <= '0;
      hdr_idx  <= '0;
      error    <= 1'b0;
    end else begin
      state <= state_nx;
      error <= (state == S_IDLE) && start && !dims_ok;
      if (accept) begin
        w_lat    <= width;
        h_lat    <= height;
        last_idx <= ADDR_BITS'(prod - 32'd1);
        hdr_idx  <= '0;
        pix_idx  <= '0;
      end
      if (state == S_HDR && ready_out) hdr_idx <= hdr_idx + 1'b1;
      if (state == S_PIX && ready_out) begin
        if (pix_idx == last_idx) pix_idx <= '0;
        else                     pix_idx <= pix_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_a) begin
    if (state == S_IDLE && load_we) mem[load_addr] <= load_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_image_frame_sender.sv
// tb/tb_image_frame_sender.sv - randomized bench for image_frame_sender against a transaction-level byte-queue model.
module tb_image_frame_sender;

  logic        clk_a = 1'b0;
  logic        rst = 1'b1;
  logic        load_we = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [7:0]  load_data = '0;
  logic [15:0] width = '0;
  logic [15:0] height = '0;
  logic        start = 1'b0;
  logic        ready_out = 1'b0;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        busy;
  logic        done;
  logic        error;

  image_frame_sender #(.DATA_BITS(8), .MAX_PIXELS(1024), .ADDR_BITS(10)) dut (
    .clk_a(clk_a), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .width(width), .height(height), .start(start), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .busy(busy), .done(done), .error(error)
  );

  always #5 clk_a = ~clk_a;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a frame is just the queue of bytes it must produce; memory is a plain array.
  logic [7:0] model_mem [0:1023];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  bit         model_busy = 0;
  bit         exp_done = 0;
  bit         exp_error = 0;
  bit         bubble_exp = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  int         beats = 0;

  always @(negedge clk_a) begin
    bit done_nx, bubble_nx, error_nx;
    logic [7:0] b;
    int prod;
    check("error", error, exp_error);
    check("done", done, exp_done);
    check("busy", busy, model_busy);
    if (bubble_exp) check("bubble", valid_out, 0);
    else if (exp_q.size() > 0) check("valid", valid_out, 1);
    else check("idle_valid", valid_out, 0);
    if (prev_stall) begin
      check("hold_valid", valid_out, 1);
      check("hold_data", data_out, prev_data);
    end
    if (valid_out && exp_q.size() > 0) check("data", data_out, exp_q[0]);
    done_nx = 0; bubble_nx = 0; error_nx = 0; prev_stall = 0;
    if (rst) begin
      exp_q.delete();
      model_busy = 0;
      beats = 0;
    end else begin
      if (valid_out && ready_out && exp_q.size() > 0) begin
        cap_q.push_back(data_out);
        b = exp_q.pop_front();
        beats++;
        if (beats == 4) bubble_nx = 1;
        if (exp_q.size() == 0) done_nx = 1;
      end
      prev_stall = valid_out && !ready_out;
      prev_data  = data_out;
      if (!model_busy) begin
        if (load_we) model_mem[load_addr] = load_data;
        if (start) begin
          prod = int'(width) * int'(height);
          if (width == 0 || height == 0 || prod > 1024) error_nx = 1;
          else begin
            exp_q = '{width[7:0], width[15:8], height[7:0], height[15:8]};
            for (int i = 0; i < prod; i++) exp_q.push_back(model_mem[i]);
            model_busy = 1;
            beats = 0;
          end
        end
      end else if (exp_done) model_busy = 0;
    end
    exp_done = done_nx; bubble_exp = bubble_nx; exp_error = error_nx;
  end

  task automatic load_mem(input bit ramp);
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk_a); #1;
      load_we   = 1'b1;
      load_addr = 10'(i);
      if (ramp)       load_data = 8'(i);
      else if (i < 4) load_data = 8'((i + 1) * 10);
      else if (i == 5) load_data = 8'h55;
      else            load_data = 8'($urandom);
    end
    @(posedge clk_a); #1;
    load_we = 1'b0;
  endtask

  task automatic run_frame(input [15:0] w, input [15:0] h, input int mode, input bit inject, output int cyc);
    cap_q.delete();
    @(posedge clk_a); #1;
    width = w; height = h; start = 1'b1;
    ready_out = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk_a); cyc++; #1;
      start = 1'b0; load_we = 1'b0;
      if (done) break;
      if (mode == 1) ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (mode == 2) begin
        ready_out = 1'($urandom_range(0, 1));
        width = 16'($urandom); height = 16'($urandom);
      end
      if (inject && cyc == 6) begin
        start = 1'b1; width = 16'd7; height = 16'd7;
        load_we = 1'b1; load_addr = 10'd5; load_data = 8'hFF;
      end
    end
    check("frame_done", done, 1);
  endtask

  task automatic bad_start(input [15:0] w, input [15:0] h);
    @(posedge clk_a); #1;
    width = w; height = h; start = 1'b1;
    @(posedge clk_a); #1;
    start = 1'b0;
    check("bad_error", error, 1);
    check("bad_busy", busy, 0);
    check("bad_valid", valid_out, 0);
    @(posedge clk_a); #1;
    check("bad_error_pulse", error, 0);
  endtask

  initial begin
    int cyc;
    int guard;
    logic [7:0] t1 [8];
    t1 = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h0A, 8'h14, 8'h1E, 8'h28};
    repeat (3) @(posedge clk_a);
    #1;
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    load_mem(0);

    run_frame(2, 2, 0, 0, cyc);
    check("t1_cycles", cyc, 10);
    check("t1_count", cap_q.size(), 8);
    for (int i = 0; i < 8 && i < cap_q.size(); i++) check("t1_byte", cap_q[i], t1[i]);

    run_frame(3, 1, 1, 0, cyc);
    check("t2_count", cap_q.size(), 7);
    if (cap_q.size() == 7) begin
      check("t2_w", cap_q[0], 8'h03);
      check("t2_h", cap_q[2], 8'h01);
      check("t2_p2", cap_q[6], 8'h1E);
    end

    bad_start(16'd0, 16'd5);
    bad_start(16'd33, 16'd32);

    run_frame(4, 4, 2, 1, cyc);
    check("t4_count", cap_q.size(), 20);
    if (cap_q.size() == 20) begin
      check("t4_w", cap_q[0], 8'h04);
      check("t4_h", cap_q[2], 8'h04);
      check("t4_p5", cap_q[9], 8'h55);
    end
    run_frame(4, 4, 0, 0, cyc);
    check("t4b_p5", cap_q.size() == 20 ? cap_q[9] : 8'h00, 8'h55);

    cap_q.delete();
    @(posedge clk_a); #1;
    width = 16'd4; height = 16'd4; start = 1'b1; ready_out = 1'b1;
    guard = 0;
    while (cap_q.size() < 7 && guard < 100) begin
      @(posedge clk_a); #1;
      start = 1'b0;
      guard++;
    end
    check("t5_reach_pix3", cap_q.size(), 7);
    rst = 1'b1;
    @(posedge clk_a); #1;
    check("t5_valid", valid_out, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    run_frame(4, 4, 0, 0, cyc);
    check("t5_cycles", cyc, 22);
    check("t5_count", cap_q.size(), 20);
    if (cap_q.size() == 20) begin
      check("t5_hdr0", cap_q[0], 8'h04);
      check("t5_p0", cap_q[4], 8'h0A);
    end

    for (int k = 0; k < 14; k++) begin
      logic [15:0] w, h;
      w = 16'($urandom_range(0, 12));
      h = 16'($urandom_range(0, 12));
      if (w == 0 || h == 0) bad_start(w, h);
      else begin
        run_frame(w, h, 2, 0, cyc);
        check("rand_count", cap_q.size(), 32'(4 + int'(w) * int'(h)));
      end
    end

    load_mem(1);
    run_frame(32, 32, 0, 0, cyc);
    check("max_cycles", cyc, 1030);
    check("max_count", cap_q.size(), 1028);
    if (cap_q.size() == 1028) begin
      check("max_last", cap_q[1027], 8'hFF);
      check("max_p300", cap_q[304], 8'h2C);
    end

    repeat (3) @(posedge clk_a);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
